// File: rtl/gcd_pkg.sv
// Shared types for the GCD job driver: FSM state encoding, response error codes
// and the default operand width of the GCD core.
package gcd_pkg;

  localparam int GCD_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_RESP  = 2'b11
  } drv_state_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_ZERO = 2'b01,
    ERR_TMO  = 2'b10
  } gcd_err_e;

endpackage

// File: rtl/gcd_drv_timer.sv
// Saturating cycle counter used to bound how long the driver waits on gcd_done.
// expired is high during the TIMEOUT-th enabled cycle after a clear.
module gcd_drv_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != TW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_job_driver.sv
// Start/Done initiator for the subtractive GCD core: takes operand pairs on a
// valid/ready port, runs one core transaction per pair and returns the result.
module gcd_job_driver
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic [1:0]       rsp_err,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic [CNT_W-1:0] job_count
);

  drv_state_e       state_q,     state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_gcd_q,   rsp_gcd_d;
  gcd_err_e         rsp_err_q,   rsp_err_d;
  logic             gcd_start_q, gcd_start_d;
  logic [WIDTH-1:0] gcd_x_q,     gcd_x_d;
  logic [WIDTH-1:0] gcd_y_q,     gcd_y_d;
  logic [CNT_W-1:0] job_count_q, job_count_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign tmr_en = (state_q == S_ISSUE) || (state_q == S_DRAIN);

  gcd_drv_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_gcd_d   = rsp_gcd_q;
    rsp_err_d   = rsp_err_q;
    gcd_start_d = gcd_start_q;
    gcd_x_d     = gcd_x_q;
    gcd_y_d     = gcd_y_q;
    job_count_d = job_count_q;
    tmr_clear   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          gcd_x_d     = req_x;
          gcd_y_d     = req_y;
          req_ready_d = 1'b0;
          rsp_gcd_d   = '0;
          tmr_clear   = 1'b1;
          // A zero operand would spin the subtractive core forever.
          if ((req_x == '0) || (req_y == '0)) begin
            rsp_err_d   = ERR_ZERO;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            rsp_err_d   = ERR_OK;
            gcd_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (gcd_done) begin
          rsp_gcd_d   = gcd_result;
          rsp_err_d   = ERR_OK;
          gcd_start_d = 1'b0;
          tmr_clear   = 1'b1;
          state_d     = S_DRAIN;
        end else if (tmr_expired) begin
          rsp_gcd_d   = '0;
          rsp_err_d   = ERR_TMO;
          gcd_start_d = 1'b0;
          tmr_clear   = 1'b1;
          state_d     = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Core must return to idle before the next job may start it again.
        if (!gcd_done) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmr_expired) begin
          rsp_gcd_d   = '0;
          rsp_err_d   = ERR_TMO;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
          if (rsp_err_q == ERR_OK) begin
            job_count_d = job_count_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_gcd_q   <= '0;
      rsp_err_q   <= ERR_OK;
      gcd_start_q <= 1'b0;
      gcd_x_q     <= '0;
      gcd_y_q     <= '0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_gcd_q   <= rsp_gcd_d;
      rsp_err_q   <= rsp_err_d;
      gcd_start_q <= gcd_start_d;
      gcd_x_q     <= gcd_x_d;
      gcd_y_q     <= gcd_y_d;
      job_count_q <= job_count_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_gcd   = rsp_gcd_q;
  assign rsp_err   = rsp_err_q;
  assign gcd_start = gcd_start_q;
  assign gcd_x     = gcd_x_q;
  assign gcd_y     = gcd_y_q;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_gcd_job_driver.sv
// Bench for gcd_job_driver: a behavioural subtractive GCD core (optionally stuck)
// drives the Start/Done side; results are checked against a Euclid model.
module tb_gcd_job_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_gcd;
  logic [1:0] rsp_err;
  logic       gcd_start;
  logic [3:0] gcd_x;
  logic [3:0] gcd_y;
  logic       gcd_done;
  logic [3:0] gcd_result;
  logic [7:0] job_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = '0;
  bit         stuck = 1'b0;

  gcd_job_driver dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_gcd   (rsp_gcd),
    .rsp_err   (rsp_err),
    .gcd_start (gcd_start),
    .gcd_x     (gcd_x),
    .gcd_y     (gcd_y),
    .gcd_done  (gcd_done),
    .gcd_result(gcd_result),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  // Reference result: Euclid by remainder.
  function automatic logic [3:0] ref_gcd(input logic [3:0] a, input logic [3:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return 4'(x);
  endfunction

  // Number of subtraction steps the core needs, and its subtractive result.
  function automatic int sub_steps(input logic [3:0] a, input logic [3:0] b);
    int x, y, n;
    x = a; y = b; n = 0;
    if (x == 0 || y == 0) return 0;
    while (x != y && n < 64) begin
      if (x > y) x = x - y; else y = y - x;
      n++;
    end
    return n;
  endfunction

  function automatic logic [3:0] sub_gcd(input logic [3:0] a, input logic [3:0] b);
    int x, y, n;
    x = a; y = b; n = 0;
    if (x == 0 || y == 0) return 4'(x + y);
    while (x != y && n < 64) begin
      if (x > y) x = x - y; else y = y - x;
      n++;
    end
    return 4'(x);
  endfunction

  // Behavioural core: loads on Start, counts down, raises Done until Start drops.
  logic core_busy;
  int   core_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcd_done   <= 1'b0;
      gcd_result <= '0;
      core_busy  <= 1'b0;
      core_cnt   <= 0;
    end else if (!gcd_start) begin
      gcd_done  <= 1'b0;
      core_busy <= 1'b0;
    end else if (!core_busy && !gcd_done && !stuck) begin
      core_busy  <= 1'b1;
      core_cnt   <= sub_steps(gcd_x, gcd_y);
      gcd_result <= sub_gcd(gcd_x, gcd_y);
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        gcd_done  <= 1'b1;
        core_busy <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job(input logic [3:0] x, input logic [3:0] y, input int hold);
    logic [3:0] eg;
    logic [1:0] ee;
    int         n;
    int         hi;
    int         exp_hi;
    bit         saw_ready;
    bit         zero;
    zero   = (x == 0) || (y == 0);
    ee     = zero ? 2'b01 : (stuck ? 2'b10 : 2'b00);
    eg     = (zero || stuck) ? 4'd0 : ref_gcd(x, y);
    exp_hi = zero ? 0 : (stuck ? 32 : sub_steps(x, y) + 3);

    req_x = x; req_y = y; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid = 1'b0;

    checks++;
    if (zero) begin
      if (rsp_valid !== 1'b1 || gcd_start !== 1'b0) begin
        errors++;
        $display("FAIL zero_latency: rsp_valid=%0b gcd_start=%0b required 1 0", rsp_valid, gcd_start);
      end
    end else if (gcd_start !== 1'b1 || gcd_x !== x || gcd_y !== y) begin
      errors++;
      $display("FAIL start_latency: start=%0b x=%0d y=%0d required 1 %0d %0d", gcd_start, gcd_x, gcd_y, x, y);
    end

    hi = 0; saw_ready = 1'b0; n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      if (gcd_start === 1'b1) hi++;
      if (req_ready === 1'b1) saw_ready = 1'b1;
      step();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid=%0b required 1 within 200 cycles", rsp_valid);
    end
    checks++;
    if (hi != exp_hi || saw_ready) begin
      errors++;
      $display("FAIL start_cycles: start_high=%0d req_ready_seen=%0b required %0d 0", hi, saw_ready, exp_hi);
    end

    for (int i = 0; i < hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_gcd !== eg || rsp_err !== ee) begin
        errors++;
        $display("FAIL rsp_hold: valid=%0b gcd=%0d err=%0d required 1 %0d %0d", rsp_valid, rsp_gcd, rsp_err, eg, ee);
      end
      step();
    end

    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_gcd !== eg || rsp_err !== ee) begin
      errors++;
      $display("FAIL rsp_data: valid=%0b gcd=%0d err=%0d required 1 %0d %0d", rsp_valid, rsp_gcd, rsp_err, eg, ee);
    end
    step();
    rsp_ready = 1'b0;
    if (ee == 2'b00) exp_cnt = exp_cnt + 8'd1;

    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rsp_valid=%0b req_ready=%0b required 0 1", rsp_valid, req_ready);
    end
    checks++;
    if (job_count !== exp_cnt) begin
      errors++;
      $display("FAIL job_count: got %0d required %0d", job_count, exp_cnt);
    end
    $display("job x=%0d y=%0d hold=%0d -> gcd=%0d err=%0d count=%0d", x, y, hold, rsp_gcd, rsp_err, job_count);
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_gcd !== 4'd0 || rsp_err !== 2'd0 ||
        gcd_start !== 1'b0 || gcd_x !== 4'd0 || gcd_y !== 4'd0 || job_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b v=%0b g=%0d e=%0d st=%0b x=%0d y=%0d cnt=%0d required 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_gcd, rsp_err, gcd_start, gcd_x, gcd_y, job_count);
    end
  endtask

  task automatic test_basic();
    do_job(4'd12, 4'd9, 0);
  endtask

  task automatic test_back_to_back();
    do_job(4'd15, 4'd10, 0);
    do_job(4'd8, 4'd4, 0);
  endtask

  task automatic test_zero();
    do_job(4'd0, 4'd5, 0);
    do_job(4'd7, 4'd0, 1);
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    do_job(4'd6, 4'd4, 0);
    stuck = 1'b0;
  endtask

  task automatic test_backpressure();
    do_job(4'd9, 4'd6, 5);
  endtask

  task automatic test_reset_mid_job();
    req_x = 4'd15; req_y = 4'd1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    checks++;
    if (gcd_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || job_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_job: start=%0b rsp_valid=%0b req_ready=%0b cnt=%0d required 0 0 1 0",
               gcd_start, rsp_valid, req_ready, job_count);
    end
    exp_cnt = '0;
    step();
    step();
    reset = 1'b1;
    step();
    do_job(4'd4, 4'd2, 0);
  endtask

  task automatic test_random();
    logic [3:0] x;
    logic [3:0] y;
    for (int k = 0; k < 40; k++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      do_job(x, y, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_timeout();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
